muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide execution unit downstream of the register file.
//  Consumes read_data_1/read_data_2 (rs1/rs2) plus funct3 and rd address.
//  Produces a 32-bit result with a one-cycle write strobe that drives the register
//  file write port: done->write_enable_flag, rd_out->a3, result->write_data_input.
//  Multi-cycle: the core stalls while busy=1.
// PARAMETERS
//  CLK_FREQ  12000000  system clock in Hz; informational only, no logic depends on it
//  XLEN      32        operand/result width; only 32 is supported
// PORTS
//  clk       in   1   system clock, all state on posedge
//  reset     in   1   synchronous, active-high reset
//  start     in   1   request; sampled only when busy=0
//  funct3    in   3   RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  rs1_data  in   32  operand A (dividend / multiplicand)
//  rs2_data  in   32  operand B (divisor / multiplier)
//  rd_in     in   5   destination register address
//  busy      out  1   high from accept edge until the edge that ends the DONE cycle
//  done      out  1   one-cycle strobe; result and rd_out are valid while high
//  result    out  32  operation result; holds its value until the next done
//  rd_out    out  5   latched rd_in; 0 is legal, the register file discards x0 writes
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0.
//    Reset overrides everything, including mid-operation; the in-flight op is dropped
//    and produces no done.
//  FSM states IDLE, CALC, DONE:
//   IDLE: start=1 at edge E0 latches operands, funct3 and rd. Go to CALC, busy=1.
//   CALC: 32 iterations on edges E1..E32, 5-bit counter 0..31.
//    At E32, register the sign-fixed result and go to DONE.
//   DONE: done=1 for exactly one cycle. The next edge returns to IDLE with busy=0 and done=0.
//    start is ignored during CALC and DONE; there is no queueing.
//  Latency: done is high in the cycle after E32, i.e. 32 cycles after the accept edge.
//    Back-to-back throughput: one op per 34 cycles.
//  Signed handling: convert to magnitudes, run the unsigned engine, negate at the end.
//   MUL/MULH: sign = sA^sB. MULHSU: rs1 signed, rs2 unsigned. MULHU/DIVU/REMU: unsigned.
//   DIV: quotient sign = sA^sB. REM: remainder takes the sign of the dividend.
//  Multiply: shift-add into a 64-bit accumulator. MUL returns [31:0]; MULH* return [63:32].
//  Divide: restoring division, one quotient bit per iteration, 33-bit partial remainder.
//  Early-out cases (no CALC): the result is registered at E1, done is high in the
//    cycle after E1, and RISC-V semantics apply:
//   divide by zero: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> rs1.
//   signed overflow, rs1=32'h8000_0000 and rs2=-1: DIV -> 32'h8000_0000, REM -> 0.
//  Operands are latched at accept. Changes to inputs while busy=1 have no effect.
// CONFIGURATION
//  FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit multiply
//    and take the early-out timing (done high in the cycle after E1).
//    Divide timing is unchanged.
//  FAST_MUL_EN undefined: all multiplies use the 32-iteration path.
//    No hardware multiplier is inferred.
// STRUCTURE
//  Shared package muldiv_pkg: enum md_op_e (the 8 funct3 encodings), enum md_state_e
//    (IDLE/CALC/DONE), localparam ITER_COUNT=32.
//  One sub-module: muldiv_iter_core, the unsigned shift-add/restoring engine, one step
//    per enable. muldiv_unit keeps the FSM, sign pre/post-processing and early-out logic.
// TESTING
//  MUL 7 x -3, no FAST_MUL_EN -> done exactly 32 cycles after accept; result=32'hFFFF_FFEB.
//  MULH 32'h8000_0000 x 32'h8000_0000 -> 32'h4000_0000.
//    MULHU 32'hFFFF_FFFF x 2 -> 32'h0000_0001.
//  DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV 5/0 -> 32'hFFFF_FFFF; REM 5/0 -> 5; DIV 32'h8000_0000/-1 -> 32'h8000_0000;
//    REM of the same -> 0. All four: done in the cycle after E1.
//  start pulsed while busy (any funct3) -> ignored; exactly one done, for the first op.
//  reset asserted mid-CALC -> next cycle busy=0, done=0, result=0; no done follows;
//    a new op completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: op encodings, FSM states, iteration count.
package muldiv_pkg;

    localparam int unsigned ITER_COUNT = 32;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } md_state_e;

    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative engine: shift-add multiply or restoring divide, one step per enable.
// hi/lo hold {product_hi, product_lo} or {remainder, quotient}; next-step values are exposed.
module muldiv_iter_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        div_mode,
    input  logic [31:0] load_lo,
    input  logic [31:0] load_opnd,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next
);

    logic        div_q;
    logic [31:0] opnd_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [32:0] rem;
    logic        fits;
    logic        unused_rem_msb;

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
        shifted = {hi_q, lo_q[31]};
        fits    = shifted >= {1'b0, opnd_q};
        trial   = shifted - {1'b0, opnd_q};
        // The partial remainder stays below the divisor, so bit 32 is always clear here.
        rem     = fits ? trial : shifted;
        if (div_q) begin
            hi_next = rem[31:0];
            lo_next = {lo_q[30:0], fits};
        end else begin
            hi_next = sum[32:1];
            lo_next = {sum[0], lo_q[31:1]};
        end
    end

    assign unused_rem_msb = rem[32];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= 1'b0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (load) begin
            div_q  <= div_mode;
            opnd_q <= load_opnd;
            hi_q   <= '0;
            lo_q   <= load_lo;
        end else if (step) begin
            hi_q <= hi_next;
            lo_q <= lo_next;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with FSM, sign handling and early-out cases.
// Optional FAST_MUL_EN: single-cycle multiplies with early-out timing.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 12000000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    md_state_e   state_q;
    md_op_e      op_q;
    logic [4:0]  cnt_q;
    logic [31:0] rs1_q, rs2_q, result_q;
    logic [4:0]  rd_q;
    logic        neg_q;

    md_op_e      op_in;
    logic        a_sgn_in, b_sgn_in, neg_in, accept;
    logic [31:0] a_mag_in, b_mag_in;
    logic        div_zero, sgn_ovf, early;
    logic [31:0] early_res, fin_res, div_val, div_fix;
    logic [63:0] mul_prod, mul_fix;
    logic [31:0] eng_hi_next, eng_lo_next;
    logic [31:0] unused_clk_freq;

    assign unused_clk_freq = CLK_FREQ;
    assign accept          = (state_q == StIdle) && start;

    always_comb begin
        op_in    = md_op_e'(funct3);
        a_sgn_in = 1'b0;
        b_sgn_in = 1'b0;
        case (op_in)
            OpMul, OpMulh, OpDiv, OpRem: begin
                a_sgn_in = 1'b1;
                b_sgn_in = 1'b1;
            end
            OpMulhsu: a_sgn_in = 1'b1;
            default: ;
        endcase
        a_mag_in = abs_if(rs1_data, a_sgn_in);
        b_mag_in = abs_if(rs2_data, b_sgn_in);
        // Remainder follows the dividend; everything else uses the xor of operand signs.
        neg_in   = (op_in == OpRem) ? (a_sgn_in & rs1_data[31])
                                    : (a_sgn_in & rs1_data[31]) ^ (b_sgn_in & rs2_data[31]);
    end

    muldiv_iter_core u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .step      ((state_q == StCalc) && !early),
        .div_mode  (funct3[2]),
        .load_lo   (funct3[2] ? a_mag_in : b_mag_in),
        .load_opnd (funct3[2] ? b_mag_in : a_mag_in),
        .hi_next   (eng_hi_next),
        .lo_next   (eng_lo_next)
    );

`ifdef FAST_MUL_EN
    logic signed [32:0] fast_a, fast_b;
    logic        [65:0] fast_prod;
    logic               unused_fast_hi;
    assign fast_a         = {(op_q != OpMulhu) & rs1_q[31], rs1_q};
    assign fast_b         = {((op_q == OpMul) || (op_q == OpMulh)) & rs2_q[31], rs2_q};
    assign fast_prod      = fast_a * fast_b;
    assign unused_fast_hi = ^fast_prod[65:64];
`endif

    always_comb begin
        div_zero = op_q[2] && (rs2_q == '0);
        sgn_ovf  = ((op_q == OpDiv) || (op_q == OpRem)) &&
                   (rs1_q == 32'h8000_0000) && (rs2_q == 32'hFFFF_FFFF);
        early    = div_zero || sgn_ovf;
        if ((op_q == OpDiv) || (op_q == OpDivu)) begin
            early_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        end else begin
            early_res = div_zero ? rs1_q : 32'd0;
        end
`ifdef FAST_MUL_EN
        if (!op_q[2]) begin
            early     = 1'b1;
            early_res = (op_q == OpMul) ? fast_prod[31:0] : fast_prod[63:32];
        end
`endif
        mul_prod = {eng_hi_next, eng_lo_next};
        mul_fix  = neg_q ? -mul_prod : mul_prod;
        div_val  = ((op_q == OpRem) || (op_q == OpRemu)) ? eng_hi_next : eng_lo_next;
        div_fix  = neg_q ? -div_val : div_val;
        if (op_q[2]) begin
            fin_res = div_fix;
        end else begin
            fin_res = (op_q == OpMul) ? mul_fix[31:0] : mul_fix[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            cnt_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StCalc;
                        op_q    <= op_in;
                        cnt_q   <= '0;
                        rs1_q   <= rs1_data;
                        rs2_q   <= rs2_data;
                        neg_q   <= neg_in;
                        rd_q    <= rd_in;
                    end
                end
                StCalc: begin
                    if (early) begin
                        result_q <= early_res;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(ITER_COUNT - 1)) begin
                            result_q <= fin_res;
                            state_q  <= StDone;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, busy-start rejection,
// mid-operation reset and randomized ops against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, result;
    logic [4:0]  rd_in, rd_out;
    logic        busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'd0, a});
        longint      ub = longint'({32'd0, b});
        int          ia = $signed(a);
        int          ib = $signed(b);
        logic [63:0] p;
        bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges after the accept edge until done is visible.
    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        bit early = op[2] && ((b == 0) ||
                    ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef FAST_MUL_EN
        if (!op[2]) early = 1'b1;
`endif
        return early ? 1 : 32;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit noisy, input string tag);
        int          cyc;
        logic [31:0] exp_r;
        exp_r = ref_model(op, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = op; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge clk); #1;
        check({tag, "/busy"}, busy, 1);
        // Inputs wander after accept; the latched copies must be used.
        start = noisy; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        rd_in = 5'($urandom);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (noisy) begin
                funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
            end
        end
        start = 1'b0;
        check({tag, "/lat"}, cyc, ref_lat(op, a, b));
        check({tag, "/res"}, result, exp_r);
        check({tag, "/rd"}, rd_out, rd);
        @(posedge clk); #1;
        check({tag, "/done_clr"}, done, 0);
        check({tag, "/idle"}, busy, 0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[$] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD},
        '{3'd1, 32'h8000_0000,  32'h8000_0000},
        '{3'd3, 32'hFFFF_FFFF,  32'd2},
        '{3'd2, 32'hFFFF_FFFF,  32'd3},
        '{3'd4, 32'hFFFF_FFF9,  32'd2},
        '{3'd6, 32'hFFFF_FFF9,  32'd2},
        '{3'd5, 32'd100,        32'd7},
        '{3'd7, 32'd100,        32'd7},
        '{3'd4, 32'd5,          32'd0},
        '{3'd6, 32'd5,          32'd0},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF}
    };

    initial begin
        int n_done;
        reset = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/result", result, 0);
        check("rst/rd", rd_out, 0);
        reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b0,
                                 $sformatf("dir%0d", i));

        // start held and re-pulsed while busy must not queue a second op.
        run_op(3'd4, 32'd1000, 32'd9, 5'd17, 1'b1, "noisy_div");
        run_op(3'd0, 32'd1234, 32'd5678, 5'd0, 1'b1, "noisy_mul");
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("noisy/extra_done", n_done, 0);

        // Reset mid-CALC drops the op entirely.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1_data = 32'd999; rs2_data = 32'd3; rd_in = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst/busy", busy, 0);
        check("midrst/done", done, 0);
        check("midrst/result", result, 0);
        check("midrst/rd", rd_out, 0);
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("midrst/no_done", n_done, 0);
        run_op(3'd5, 32'd999, 32'd3, 5'd9, 1'b0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), rand_opnd(), rand_opnd(), 5'($urandom), 1'(i % 4 == 0),
                   $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
